// File: rtl/sdlib_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sdlib_pkg
// Description : Shared helpers for the srdy/drdy library. Only a weight
//               constant helper lives here; there are no typedefs, so blocks
//               using it stay free to pick any width/weight_sz.
// Revision    : 1.0  initial release
// ============================================================================
package sdlib_pkg;

  // Largest weight a weight_sz-bit field can hold.
  function automatic int SD_WRR_WMAX(input int wsz);
    return (1 << wsz) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_wrrdemux2_if.sv
`default_nettype none
// ============================================================================
// Interface   : sd_wrrdemux2_if
// Description : Bundles the consumer-side (c_*) input stream and the two
//               producer-side (p_*) output streams of sd_wrrdemux2.
//   c_srdy/c_drdy/c_data : input stream handshake and payload
//   c_weight             : {w1, w0} per-output weights
//   c_grant              : one-hot destination of this cycle's transfer
//   p_srdy/p_drdy/p_data : two output streams, payload i at [i*width +: width]
//   modport master : the environment (drives the input side, consumes outputs)
//   modport slave  : the distributor itself
// Revision    : 1.0  initial release
// ============================================================================
interface sd_wrrdemux2_if #(
  parameter int width     = 8,
  parameter int weight_sz = 2
);
  logic                   c_srdy;
  logic                   c_drdy;
  logic [width-1:0]       c_data;
  logic [2*weight_sz-1:0] c_weight;
  logic [1:0]             c_grant;
  logic [1:0]             p_srdy;
  logic [1:0]             p_drdy;
  logic [2*width-1:0]     p_data;

  modport master (
    output c_srdy, c_data, c_weight, p_drdy,
    input  c_drdy, c_grant, p_srdy, p_data
  );

  modport slave (
    input  c_srdy, c_data, c_weight, p_drdy,
    output c_drdy, c_grant, p_srdy, p_data
  );
endinterface
`default_nettype wire

// File: rtl/sd_wrrdemux2_oreg.sv
`default_nettype none
// ============================================================================
// Module      : sd_wrrdemux2_oreg
// Description : 1-entry srdy/drdy output register. A load overrides a drain
//               in the same cycle, so the slot sustains one beat per cycle.
//   clk, reset : clock, asynchronous active-high reset
//   load       : write load_data into the slot this cycle
//   load_data  : payload to store
//   drdy       : downstream ready
//   srdy       : slot holds a valid beat
//   data       : stored payload (held until drained)
// Revision    : 1.0  initial release
// ============================================================================
module sd_wrrdemux2_oreg #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] load_data,
  input  logic             drdy,
  output logic             srdy,
  output logic [width-1:0] data
);

  logic             r_ov;
  logic [width-1:0] r_od;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ov <= 1'b0;
      r_od <= '0;
    end else if (load) begin
      r_ov <= 1'b1;
      r_od <= load_data;
    end else if (r_ov && drdy) begin
      r_ov <= 1'b0;
    end
  end

  assign srdy = r_ov;
  assign data = r_od;

endmodule
`default_nettype wire

// File: rtl/sd_wrrdemux2.sv
`default_nettype none
// ============================================================================
// Module      : sd_wrrdemux2
// Description : 2-output weighted-round-robin distributor. Sends w0 beats to
//               output 0, then w1 beats to output 1, and repeats. Each output
//               has a 1-entry register, so latency is one cycle.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : sd_wrrdemux2_if.slave (c_* input stream, c_weight, c_grant,
//                p_* output streams)
// Config      : define SD_WRRDEMUX2_SKIP_EN for work-conserving operation:
//               a beat that cannot go to the current target goes to the other
//               output instead, without consuming either turn.
// Revision    : 1.0  initial release
// ============================================================================
module sd_wrrdemux2
  import sdlib_pkg::*;
#(
  parameter int width     = 8,
  parameter int weight_sz = 2
) (
  input  logic          clk,
  input  logic          reset,
  sd_wrrdemux2_if.slave bus
);

  localparam logic [weight_sz-1:0] c_wmax = weight_sz'(SD_WRR_WMAX(weight_sz));

  logic                 r_sel;
  logic [weight_sz-1:0] r_cnt;

  logic [weight_sz-1:0] w_w0, w_w1, w_ws, w_wo;
  logic [1:0]           w_ov, w_ok, w_load;
  logic [2*width-1:0]   w_od;
  logic                 w_skip, w_dest, w_xfer, w_turn_xfer, w_turn_end;
  logic [weight_sz:0]   w_cnt_inc;

  assign w_w0 = bus.c_weight[0 +: weight_sz];
  assign w_w1 = bus.c_weight[weight_sz +: weight_sz];
  assign w_ws = r_sel ? w_w1 : w_w0;
  assign w_wo = r_sel ? w_w0 : w_w1;

  // A slot can accept when empty or draining this cycle.
  assign w_ok = ~w_ov | bus.p_drdy;

`ifdef SD_WRRDEMUX2_SKIP_EN
  // Divert to the other output when the target is full; ws==0 keeps the
  // ordinary one-bubble handover instead.
  assign w_skip = ~w_ok[r_sel] & (w_wo != '0) & w_ok[~r_sel];
`else
  assign w_skip = 1'b0;
`endif

  assign bus.c_drdy  = (w_ws != '0) & (w_ok[r_sel] | w_skip);
  assign w_dest      = w_skip ? ~r_sel : r_sel;
  assign w_xfer      = bus.c_srdy & bus.c_drdy;
  assign w_load      = w_xfer ? (2'b01 << w_dest) : 2'b00;
  assign bus.c_grant = w_load;

  // Only beats delivered to the current target count toward its turn.
  assign w_turn_xfer = w_xfer & ~w_skip;
  // Widened compare so cnt+1 never wraps; a weight lowered below cnt ends
  // the turn on the next transfer.
  assign w_cnt_inc   = {1'b0, r_cnt} + 1'b1;
  assign w_turn_end  = (w_cnt_inc >= {1'b0, w_ws});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel <= 1'b0;
      r_cnt <= '0;
    end else if (w_turn_xfer) begin
      if (w_turn_end) begin
        r_sel <= ~r_sel;
        r_cnt <= '0;
      end else begin
        r_cnt <= (r_cnt == c_wmax) ? r_cnt : r_cnt + 1'b1;
      end
    end else if ((w_ws == '0) && (w_wo != '0)) begin
      // Zero-weight target: hand the turn over, costing one bubble.
      r_sel <= ~r_sel;
      r_cnt <= '0;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_oreg
    sd_wrrdemux2_oreg #(.width(width)) u_oreg (
      .clk       (clk),
      .reset     (reset),
      .load      (w_load[i]),
      .load_data (bus.c_data),
      .drdy      (bus.p_drdy[i]),
      .srdy      (w_ov[i]),
      .data      (w_od[i*width +: width])
    );
  end

  assign bus.p_srdy = w_ov;
  assign bus.p_data = w_od;

endmodule
`default_nettype wire
